// File: rtl/mem_exec_unit.sv
// mem_exec_unit: single-lane load/store execution unit at the output of the memory issue queue.
// It accepts one issued uop, performs one memory access over a req/gnt + response
// handshake, and then emits a one-cycle writeback/completion pulse.
//
// Ports:
//   clock, reset_n        single clock, asynchronous active-low reset
//   clear_en              synchronous pipeline flush
//   in_*                  issued uop and its PRF operand values
//   ex_busy               unit is not idle; the issue queue must hold off
//   mem_*                 data-memory request (req/we/addr/wdata/wstrb) and response
//   wb_*                  completion pulse, PRF write port and misalignment flag
module mem_exec_unit #(
  parameter int unsigned XLEN           = 32,
  parameter int unsigned PRF_INDEX_SIZE = 6
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      clear_en,
  input  logic                      in_valid,
  input  logic                      in_is_store,
  input  logic [1:0]                in_size,
  input  logic                      in_signed,
  input  logic [XLEN-1:0]           in_base,
  input  logic [XLEN-1:0]           in_offset,
  input  logic [XLEN-1:0]           in_store_data,
  input  logic [PRF_INDEX_SIZE-1:0] in_rd_index,
  output logic                      ex_busy,
  output logic                      mem_req,
  output logic                      mem_we,
  output logic [XLEN-1:0]           mem_addr,
  output logic [XLEN-1:0]           mem_wdata,
  output logic [3:0]                mem_wstrb,
  input  logic                      mem_gnt,
  input  logic                      mem_resp_valid,
  input  logic [XLEN-1:0]           mem_rdata,
  output logic                      wb_valid,
  output logic                      wb_we,
  output logic [PRF_INDEX_SIZE-1:0] wb_rd_index,
  output logic [XLEN-1:0]           wb_data,
  output logic                      wb_misaligned
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StWb, StDrain} state_e;

  state_e                    state_q, state_d;
  logic                      is_store_q;
  logic [1:0]                size_q;
  logic                      signed_q;
  logic [XLEN-1:0]           addr_q;
  logic [XLEN-1:0]           wdata_q;
  logic [3:0]                wstrb_q;
  logic [XLEN-1:0]           data_q;
  logic [PRF_INDEX_SIZE-1:0] rd_q;
  logic                      misaligned_q;

  logic [XLEN-1:0] addr_calc;
  logic            misaligned_calc;
  logic [3:0]      strb_base;
  logic            accept;
  logic            load_resp;
  logic [XLEN-1:0] rshift;
  logic [XLEN-1:0] load_ext;

  assign addr_calc = in_base + in_offset;

  always_comb begin
    misaligned_calc = 1'b0;
    strb_base       = 4'b0000;
    case (in_size)
      2'b00: strb_base = 4'b0001;
      2'b01: begin
        strb_base       = 4'b0011;
        misaligned_calc = addr_calc[0];
      end
      2'b10: begin
        strb_base       = 4'b1111;
        misaligned_calc = |addr_calc[1:0];
      end
      default: misaligned_calc = 1'b1;
    endcase
  end

  // Flush wins over a new issue and over a completing response.
  assign accept    = (state_q == StIdle) && in_valid && !clear_en;
  assign load_resp = (state_q == StWait) && mem_resp_valid && !clear_en;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && !clear_en) state_d = misaligned_calc ? StWb : StReq;
      end
      StReq: begin
        // A grant already handed out must have its response swallowed in DRAIN.
        if (clear_en)     state_d = mem_gnt ? StDrain : StIdle;
        else if (mem_gnt) state_d = StWait;
      end
      StWait: begin
        if (clear_en)            state_d = mem_resp_valid ? StIdle : StDrain;
        else if (mem_resp_valid) state_d = StWb;
      end
      StWb:    state_d = StIdle;
      StDrain: if (mem_resp_valid) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bring the addressed bytes down to bit 0, then extend to XLEN.
  assign rshift = mem_rdata >> {addr_q[1:0], 3'b000};

  always_comb begin
    load_ext = rshift;
    case (size_q)
      2'b00:   load_ext = {{(XLEN-8){signed_q & rshift[7]}}, rshift[7:0]};
      2'b01:   load_ext = {{(XLEN-16){signed_q & rshift[15]}}, rshift[15:0]};
      default: load_ext = rshift;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= StIdle;
      is_store_q   <= 1'b0;
      size_q       <= 2'b00;
      signed_q     <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      wstrb_q      <= 4'b0000;
      data_q       <= '0;
      rd_q         <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        is_store_q   <= in_is_store;
        size_q       <= in_size;
        signed_q     <= in_signed;
        addr_q       <= addr_calc;
        rd_q         <= in_rd_index;
        misaligned_q <= misaligned_calc;
        wdata_q      <= in_is_store ? (in_store_data << {addr_calc[1:0], 3'b000}) : '0;
        wstrb_q      <= (in_is_store && !misaligned_calc) ? (strb_base << addr_calc[1:0])
                                                          : 4'b0000;
        // Stores and faults complete with zero data.
        data_q       <= '0;
      end else if (load_resp && !is_store_q) begin
        data_q <= load_ext;
      end
    end
  end

  // All outputs are decoded from registered state only.
  assign ex_busy       = (state_q != StIdle);
  assign mem_req       = (state_q == StReq);
  assign mem_we        = mem_req & is_store_q;
  assign mem_addr      = mem_req ? addr_q : '0;
  assign mem_wdata     = mem_req ? wdata_q : '0;
  assign mem_wstrb     = mem_req ? wstrb_q : 4'b0000;
  assign wb_valid      = (state_q == StWb);
  assign wb_we         = wb_valid & ~is_store_q & ~misaligned_q & (rd_q != '0);
  assign wb_rd_index   = wb_valid ? rd_q : '0;
  assign wb_data       = wb_valid ? data_q : '0;
  assign wb_misaligned = wb_valid & misaligned_q;

endmodule
